mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 15 +
 rtl/rr_pick2.sv | 23 ++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   MEM_ADDR_W / MEM_DATA_W : default address and data widths
//   state_t                 : arbiter FSM state encoding
package mem_pkg;

  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin winner selection (purely combinational).
// Ports:
//   req      : request vector, bit 0 = CPU, bit 1 = loader/debug
//   last_gnt : port that received the most recent grant
//   winner   : selected port index (meaningful only when req != 0)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      // Tie: the port that did not win last time goes first.
      2'b11:   winner = ~last_gnt;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter with round-robin fairness.
// Port 0 is the CPU, port 1 the loader/debug port. A request seen in IDLE
// produces, one cycle later, a one-cycle gnt pulse together with the memory
// strobe, address and write data (ACCESS). Reads then spend one cycle in
// RDWAIT while the memory returns data, and rvalid/rdata appear the cycle
// after that. All outputs are registered.
// Ports:
//   clk, reset                 : clock (rising edge), async active-high reset
//   req_p, we_p, addr_p,
//   wdata_p (p = 0,1)          : requester inputs, held stable until granted
//   gnt_p, rvalid_p, rdata_p   : accept pulse, read-valid pulse, read data
//   rd_mem, wr_mem             : memory strobes (only during ACCESS)
//   adr_bus, data_bus_out      : memory address / write data (only in ACCESS)
//   data_bus_in                : memory read data, valid the cycle after rd_mem
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [ADDR_W-1:0] adr_bus,
  output logic [DATA_W-1:0] data_bus_out,
  input  logic [DATA_W-1:0] data_bus_in
);

  state_t            state_q,    state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              win_q,      win_d;
  logic              we_q,       we_d;
  logic [1:0]        gnt_q,      gnt_d;
  logic [1:0]        rvalid_q,   rvalid_d;
  logic [DATA_W-1:0] rdata0_q,   rdata0_d;
  logic [DATA_W-1:0] rdata1_q,   rdata1_d;
  logic              rd_q,       rd_d;
  logic              wr_q,       wr_d;
  logic [ADDR_W-1:0] adr_q,      adr_d;
  logic [DATA_W-1:0] dout_q,     dout_d;

  logic [1:0]        req_vec;
  logic              winner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign req_vec = {req_1, req_0};

  rr_pick2 u_pick (
    .req      (req_vec),
    .last_gnt (last_gnt_q),
    .winner   (winner)
  );

  assign win_we    = winner ? we_1    : we_0;
  assign win_addr  = winner ? addr_1  : addr_0;
  assign win_wdata = winner ? wdata_1 : wdata_0;

  // The address/data output registers double as the latched request: they
  // are loaded on the grant edge, so they hold the winner's values exactly
  // for the ACCESS cycle and fall back to zero afterwards.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    win_d      = win_q;
    we_d       = we_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    adr_d      = '0;
    dout_d     = '0;

    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          state_d       = ACCESS;
          win_d         = winner;
          last_gnt_d    = winner;
          we_d          = win_we;
          gnt_d[winner] = 1'b1;
          wr_d          = win_we;
          rd_d          = ~win_we;
          adr_d         = win_addr;
          dout_d        = win_we ? win_wdata : '0;
        end
      end
      ACCESS: begin
        state_d = we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        state_d         = IDLE;
        rvalid_d[win_q] = 1'b1;
        if (win_q) rdata1_d = data_bus_in;
        else       rdata0_d = data_bus_in;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      adr_q      <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      win_q      <= win_d;
      we_q       <= we_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      adr_q      <= adr_d;
      dout_q     <= dout_d;
    end
  end

  assign gnt_0        = gnt_q[0];
  assign gnt_1        = gnt_q[1];
  assign rvalid_0     = rvalid_q[0];
  assign rvalid_1     = rvalid_q[1];
  assign rdata_0      = rdata0_q;
  assign rdata_1      = rdata1_q;
  assign rd_mem       = rd_q;
  assign wr_mem       = wr_q;
  assign adr_bus      = adr_q;
  assign data_bus_out = dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a simple memory model.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_0 = 1'b0, we_0 = 1'b0;
  logic [AW-1:0] addr_0 = '0;
  logic [DW-1:0] wdata_0 = '0;
  logic          req_1 = 1'b0, we_1 = 1'b0;
  logic [AW-1:0] addr_1 = '0;
  logic [DW-1:0] wdata_1 = '0;
  logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
  logic [DW-1:0] rdata_0, rdata_1;
  logic          rd_mem, wr_mem;
  logic [AW-1:0] adr_bus;
  logic [DW-1:0] data_bus_out;
  logic [DW-1:0] data_bus_in;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_0        (req_0),
    .we_0         (we_0),
    .addr_0       (addr_0),
    .wdata_0      (wdata_0),
    .req_1        (req_1),
    .we_1         (we_1),
    .addr_1       (addr_1),
    .wdata_1      (wdata_1),
    .gnt_0        (gnt_0),
    .gnt_1        (gnt_1),
    .rvalid_0     (rvalid_0),
    .rvalid_1     (rvalid_1),
    .rdata_0      (rdata_0),
    .rdata_1      (rdata_1),
    .rd_mem       (rd_mem),
    .wr_mem       (wr_mem),
    .adr_bus      (adr_bus),
    .data_bus_out (data_bus_out),
    .data_bus_in  (data_bus_in)
  );

  always #5 clk = ~clk;

  // Memory: writes on wr_mem, read data returned the cycle after rd_mem.
  logic [DW-1:0] mem [64];
  int unsigned   wr_count = 0;
  int unsigned   rd_count = 0;

  always @(posedge clk) begin
    if (wr_mem) begin
      mem[adr_bus] <= data_bus_out;
      wr_count     <= wr_count + 1;
    end
    if (rd_mem) rd_count <= rd_count + 1;
    data_bus_in <= rd_mem ? mem[adr_bus] : '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"},    {30'd0, gnt_1, gnt_0}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, rvalid_1, rvalid_0}, 32'd0);
    chk({tag, "_rd"},     {31'd0, rd_mem}, 32'd0);
    chk({tag, "_wr"},     {31'd0, wr_mem}, 32'd0);
    chk({tag, "_adr"},    {26'd0, adr_bus}, 32'd0);
    chk({tag, "_dout"},   {24'd0, data_bus_out}, 32'd0);
  endtask

  task automatic do_reset();
    req_0 = 1'b0;
    req_1 = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int unsigned g0, g1, wr_snap, rd_snap;

  initial begin
    // ---------------- reset state
    tick();
    tick();
    chk_idle_outputs("rst");
    chk("rst_rdata0", {24'd0, rdata_0}, 32'h0);
    chk("rst_rdata1", {24'd0, rdata_1}, 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(mem_pkg::IDLE));
    chk("rst_lastgnt", {31'd0, dut.last_gnt_q}, 32'd1);
    reset = 1'b0;

    // ---------------- port 0 write 05 <- A5 in first cycle after reset
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 6'h05; wdata_0 = 8'hA5;
    tick();
    chk("w0_gnt0", {31'd0, gnt_0}, 32'd1);
    chk("w0_gnt1", {31'd0, gnt_1}, 32'd0);
    chk("w0_wr", {31'd0, wr_mem}, 32'd1);
    chk("w0_rd", {31'd0, rd_mem}, 32'd0);
    chk("w0_adr", {26'd0, adr_bus}, 32'h05);
    chk("w0_dout", {24'd0, data_bus_out}, 32'hA5);
    req_0 = 1'b0;
    tick();
    chk_idle_outputs("w0_after");
    chk("w0_mem5", {24'd0, mem[5]}, 32'hA5);

    // ---------------- port 1 read 05
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 6'h05;
    tick();
    chk("r1_gnt1", {31'd0, gnt_1}, 32'd1);
    chk("r1_rd", {31'd0, rd_mem}, 32'd1);
    chk("r1_wr", {31'd0, wr_mem}, 32'd0);
    chk("r1_adr", {26'd0, adr_bus}, 32'h05);
    chk("r1_dout", {24'd0, data_bus_out}, 32'h0);
    req_1 = 1'b0;
    tick();
    chk("r1_t2_rvalid", {31'd0, rvalid_1}, 32'd0);
    chk("r1_t2_rd", {31'd0, rd_mem}, 32'd0);
    chk("r1_t2_state", 32'(dut.state_q), 32'(mem_pkg::RDWAIT));
    tick();
    chk("r1_t3_rvalid1", {31'd0, rvalid_1}, 32'd1);
    chk("r1_t3_rvalid0", {31'd0, rvalid_0}, 32'd0);
    chk("r1_t3_rdata1", {24'd0, rdata_1}, 32'hA5);
    chk("r1_t3_rdata0", {24'd0, rdata_0}, 32'h0);
    tick();
    chk("r1_t4_rvalid1", {31'd0, rvalid_1}, 32'd0);
    chk("r1_t4_rdata1_hold", {24'd0, rdata_1}, 32'hA5);

    // ---------------- simultaneous writes after reset: port 0 first
    do_reset();
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 6'h01; wdata_0 = 8'h11;
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 6'h02; wdata_1 = 8'h22;
    tick();
    chk("tie_t1_gnt0", {31'd0, gnt_0}, 32'd1);
    chk("tie_t1_gnt1", {31'd0, gnt_1}, 32'd0);
    chk("tie_t1_adr", {26'd0, adr_bus}, 32'h01);
    req_0 = 1'b0;
    tick();
    chk_idle_outputs("tie_t2");
    tick();
    chk("tie_t3_gnt1", {31'd0, gnt_1}, 32'd1);
    chk("tie_t3_gnt0", {31'd0, gnt_0}, 32'd0);
    chk("tie_t3_adr", {26'd0, adr_bus}, 32'h02);
    chk("tie_t3_dout", {24'd0, data_bus_out}, 32'h22);
    req_1 = 1'b0;
    tick();
    chk("tie_mem1", {24'd0, mem[1]}, 32'h11);
    chk("tie_mem2", {24'd0, mem[2]}, 32'h22);

    // ---------------- continuous contention: alternation, no starvation
    do_reset();
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 6'h0A; wdata_0 = 8'h0A;
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 6'h14; wdata_1 = 8'h14;
    g0 = 0;
    g1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("alt%0d_gnt0", i), {31'd0, gnt_0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("alt%0d_gnt1", i), {31'd0, gnt_1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (gnt_0) g0++;
      if (gnt_1) g1++;
      if (i == 7) begin
        req_0 = 1'b0;
        req_1 = 1'b0;
      end
      tick();
      chk($sformatf("alt%0d_gap", i), {30'd0, gnt_1, gnt_0}, 32'd0);
    end
    chk("alt_count0", g0, 32'd4);
    chk("alt_count1", g1, 32'd4);
    tick();
    chk("alt_quiet", {30'd0, gnt_1, gnt_0}, 32'd0);

    // ---------------- reset during RDWAIT of a port 0 read
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 6'h05;
    tick();
    chk("ab_gnt0", {31'd0, gnt_0}, 32'd1);
    chk("ab_rd", {31'd0, rd_mem}, 32'd1);
    req_0 = 1'b0;
    tick();
    chk("ab_state_rdwait", 32'(dut.state_q), 32'(mem_pkg::RDWAIT));
    reset = 1'b1;
    #1;
    chk_idle_outputs("ab_rst");
    chk("ab_state", 32'(dut.state_q), 32'(mem_pkg::IDLE));
    chk("ab_rdata0", {24'd0, rdata_0}, 32'h0);
    tick();
    chk("ab_no_rvalid0", {31'd0, rvalid_0}, 32'd0);
    chk("ab_rdata0_hold", {24'd0, rdata_0}, 32'h0);
    reset = 1'b0;

    // ---------------- port 1 short request during port 0 read is ignored
    wr_snap = wr_count;
    rd_snap = rd_count;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 6'h02;
    tick();
    chk("sh_gnt0", {31'd0, gnt_0}, 32'd1);
    chk("sh_rd", {31'd0, rd_mem}, 32'd1);
    req_0 = 1'b0;
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 6'h07; wdata_1 = 8'h77;
    tick();
    chk("sh_t2_gnt1", {31'd0, gnt_1}, 32'd0);
    chk("sh_t2_wr", {31'd0, wr_mem}, 32'd0);
    req_1 = 1'b0;
    tick();
    chk("sh_t3_rvalid0", {31'd0, rvalid_0}, 32'd1);
    chk("sh_t3_rdata0", {24'd0, rdata_0}, 32'h22);
    chk("sh_t3_gnt1", {31'd0, gnt_1}, 32'd0);
    chk("sh_t3_rdata1", {24'd0, rdata_1}, 32'h0);
    tick();
    chk_idle_outputs("sh_t4");
    chk("sh_state", 32'(dut.state_q), 32'(mem_pkg::IDLE));
    chk("sh_wr_count", wr_count, wr_snap);
    chk("sh_rd_count", rd_count, rd_snap + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
